// File: rtl/seq_add_ctrl_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder controller.
package seq_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calc_nch(input int n, input int w);
        return n / w;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int calc_idx_width(input int n, input int w);
        int nch;
        nch = n / w;
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/seq_add_ctrl_fulladder.sv
// Parameterised N-bit ripple full adder, used here as the shared W-bit slice.
module fulladderNb #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/seq_add_ctrl.sv
// Adds two N-bit operands over N/W cycles on one W-bit slice, LS chunk first,
// with valid/ready handshakes on both the operand and result sides.
module seq_add_ctrl
    import seq_add_ctrl_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NCH = calc_nch(N, W);
    localparam int IW  = calc_idx_width(N, W);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if ((N % W) != 0) begin : g_bad_width
        $error("seq_add_ctrl: N must be an exact multiple of W");
    end

    state_t         state;
    state_t         next_state;
    logic [IW-1:0]  idx;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   sum_reg;
    logic           carry_reg;
    logic [W-1:0]   a_chunk;
    logic [W-1:0]   b_chunk;
    logic [W-1:0]   slice_sum;
    logic           slice_cout;

    assign a_chunk = a_reg[int'(idx)*W +: W];
    assign b_chunk = b_reg[int'(idx)*W +: W];

    fulladderNb #(
        .N (W)
    ) u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .s    (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)   next_state = RUN;
            RUN:     if (idx == LAST) next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset clears the result so an abandoned addition never leaves a partial sum visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[int'(idx)*W +: W] <= slice_sum;
                    carry_reg                 <= slice_cout;
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = carry_reg;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench: directed vector table and corner sequences on N=16/W=4,
// plus random back-to-back sweeps on W=16 and W=1 instances.
module tb_seq_add_ctrl;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_add_ctrl #(
        .N (16),
        .W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Called #1 after an edge; returns edges from acceptance to out_valid, or -1.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vc, output int lat);
        int n;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            lat      = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("consume_in_ready", 32'(in_ready), 32'd1);
        checkOutput("consume_out_valid", 32'(out_valid), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        int lat;
        int n;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'hAAAA;
        b         = 16'h5555;
        cin       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            checkOutput($sformatf("latency_%0d", i), 32'(lat), 32'd4);
            checkOutput($sformatf("sum_%0d", i), 32'(sum), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("cout_%0d", i), 32'(cout), 32'(vecs[i].exp_cout));
            consume();
        end

        $display("[TB] backpressure");
        applyStimulus(16'h1111, 16'h2222, 1'b0, lat);
        checkOutput("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 16'hDEAD + 16'(i);
            b        = 16'hBEEF;
            cin      = 1'b1;
            @(posedge clk); #1;
            checkOutput("bp_sum", 32'(sum), 32'h3333);
            checkOutput("bp_cout", 32'(cout), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        consume();

        $display("[TB] reset while result pending");
        applyStimulus(16'h1234, 16'h1111, 1'b0, lat);
        checkOutput("pend_sum", 32'(sum), 32'h2345);
        in_valid = 1'b1;
        a        = 16'h0005;
        b        = 16'h0007;
        cin      = 1'b1;
        rst      = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_sum", 32'(sum), 32'd0);
        checkOutput("midrst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        checkOutput("midrst_hold_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("postrst_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("postrst_latency", 32'(lat), 32'd4);
        checkOutput("postrst_sum", 32'(sum), 32'h000D);
        checkOutput("postrst_cout", 32'(cout), 32'd0);
        consume();

        $display("[TB] reset during RUN");
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n        = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        checkOutput("runrst_no_out_valid", 32'(n), 32'd0);
        checkOutput("runrst_idle", 32'(in_ready), 32'd1);
        applyStimulus(16'h0001, 16'h0001, 1'b0, lat);
        checkOutput("runrst_latency", 32'(lat), 32'd4);
        checkOutput("runrst_sum", 32'(sum), 32'h0002);
        checkOutput("runrst_cout", 32'(cout), 32'd0);
        consume();

        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_sweep[0].done && g_sweep[1].done)) begin
            checkOutput("sweep_timeout", 32'd0, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SW   = (g == 0) ? 16 : 1;
        localparam int SNCH = 16 / SW;

        logic        s_rst;
        logic        s_in_valid;
        logic        s_in_ready;
        logic [15:0] s_a;
        logic [15:0] s_b;
        logic        s_cin;
        logic        s_out_valid;
        logic        s_out_ready;
        logic [15:0] s_sum;
        logic        s_cout;
        bit          done = 1'b0;

        seq_add_ctrl #(
            .N (16),
            .W (SW)
        ) dut_s (
            .clk       (clk),
            .rst       (s_rst),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_cin),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .sum       (s_sum),
            .cout      (s_cout)
        );

        initial begin
            int          lat;
            int          n;
            logic [16:0] expv;

            s_rst       = 1'b1;
            s_in_valid  = 1'b0;
            s_a         = '0;
            s_b         = '0;
            s_cin       = 1'b0;
            s_out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            s_rst = 1'b0;
            for (int t = 0; t < 200; t++) begin
                s_a        = 16'($urandom);
                s_b        = 16'($urandom);
                s_cin      = 1'($urandom);
                expv       = {1'b0, s_a} + {1'b0, s_b} + {16'd0, s_cin};
                s_in_valid = 1'b1;
                n          = 0;
                while (!s_in_ready && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                @(posedge clk); #1;
                s_in_valid = 1'b0;
                lat        = 0;
                while (!s_out_valid && lat < 40) begin
                    @(posedge clk); #1;
                    lat++;
                end
                checkOutput($sformatf("sweep_w%0d_latency", SW), 32'(lat), 32'(SNCH));
                checkOutput($sformatf("sweep_w%0d_result", SW), 32'({s_cout, s_sum}), 32'(expv));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                s_out_ready = 1'b1;
                @(posedge clk); #1;
                s_out_ready = 1'b0;
                checkOutput($sformatf("sweep_w%0d_in_ready", SW), 32'(s_in_ready), 32'd1);
            end
            done = 1'b1;
        end
    end

endmodule
